regfile_mp_sb: RTL and testbench

- Parametrised successor to the team's 32x32 register file.
- N combinational read ports with write-through bypass, one write port, and a per-register pending-write scoreboard for pipeline hazard detection.
- Adds a sticky halt on `done`, and a reset-time argument register preload.
- Sits between decode (reads, reservations) and writeback (writes) in the pipelined CPU.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 41 ++++
 rtl/regfile_mp_sb.sv | 91 +++++++++
 tb/tb_regfile_mp_sb.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;
  localparam int DW_DEF      = 32;
  localparam int AW_DEF      = 5;
  localparam int ARG_REG_DEF = 10;

  // Bit offset of port i's field in a flattened multi-port bus of width w
  function automatic int rd_off(input int i, input int w);
    return i * w;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits: set by a reservation, cleared by the write
// that retires it, wiped by a pipeline flush. Frozen while en is low.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  output logic [2**AW-1:0]  busy_mask
);
  logic [2**AW-1:0] busy_q, busy_d;

  // Next busy state: flush wins, else clear then set so a same-cycle
  // reserve of the written register leaves it pending.
  always_comb begin
    busy_d = busy_q;
    if (en) begin
      if (flush) begin
        busy_d = '0;
      end else begin
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en && set_addr != '0) busy_d[set_addr] = 1'b1;
      end
    end
  end

  // Busy bit storage
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_mask = busy_q;
endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with write-through bypass, pending-write
// scoreboard, sticky halt on done and argument-register preload at reset.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int NR      = 2,
  parameter int ARG_REG = ARG_REG_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [NR-1:0]      ren,
  input  logic [NR*AW-1:0]   raddr,
  output logic [NR*DW-1:0]   rdata,
  output logic [NR-1:0]      conflict,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [DW-1:0]      wdata,
  input  logic               rsv_en,
  input  logic [AW-1:0]      rsv_addr,
  input  logic [DW-1:0]      init_val,
  input  logic               done,
  output logic               halted,
  output logic [2**AW-1:0]   busy_mask,
  input  logic [AW-1:0]      dbg_addr,
  output logic [DW-1:0]      dbg_data
);
  localparam int NREG = 2**AW;

  logic [NREG-1:0][DW-1:0] regs_q, regs_d;
  logic                    halted_q, halted_d;
  logic                    wen_eff;

  // done blocks the write in its own cycle, not just from the next one
  assign wen_eff = we && (waddr != '0) && !halted_q && !done;

  // Next register contents and sticky halt
  always_comb begin
    regs_d = regs_q;
    if (wen_eff) regs_d[waddr] = wdata;
    halted_d = halted_q | done;
  end

  // Register array and halt flag; reset preloads the argument register
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q          <= '0;
      regs_q[ARG_REG] <= init_val;
      halted_q        <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      halted_q <= halted_d;
    end
  end

  regfile_scoreboard #(.AW(AW)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .en        (!halted_q),
    .flush     (flush),
    .clr_en    (wen_eff),
    .clr_addr  (waddr),
    .set_en    (rsv_en),
    .set_addr  (rsv_addr),
    .busy_mask (busy_mask)
  );

  // Per-port read mux with bypass and hazard detect
  for (genvar gi = 0; gi < NR; gi++) begin : g_rd
    localparam int AOFF = rd_off(gi, AW);
    localparam int DOFF = rd_off(gi, DW);
    logic [AW-1:0] ra;
    logic          hit_w;
    assign ra    = raddr[AOFF +: AW];
    assign hit_w = wen_eff && (waddr == ra);

    // Zero register, then in-flight write, then stored value
    always_comb begin
      if (ra == '0)  rdata[DOFF +: DW] = '0;
      else if (hit_w) rdata[DOFF +: DW] = wdata;
      else            rdata[DOFF +: DW] = regs_q[ra];
    end

    assign conflict[gi] = ren[gi] && (ra != '0) && busy_mask[ra] && !hit_w;
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
  assign halted   = halted_q;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: reset preload, a cycle table of
// bypass/scoreboard cases, then hand-written halt and re-reset sequences.
module tb_regfile_mp_sb;
  logic        clk = 1'b0;
  logic        rst, flush, we, rsv_en, done;
  logic [1:0]  ren;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  conflict;
  logic [4:0]  waddr, rsv_addr, dbg_addr;
  logic [31:0] wdata, init_val, dbg_data, busy_mask;
  logic        halted;

  int checks = 0;
  int failures = 0;

  regfile_mp_sb dut (
    .clk(clk), .rst(rst), .flush(flush), .ren(ren), .raddr(raddr),
    .rdata(rdata), .conflict(conflict), .we(we), .waddr(waddr),
    .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .init_val(init_val), .done(done), .halted(halted),
    .busy_mask(busy_mask), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  ren;
    logic [4:0]  ra0, ra1;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;
    logic [31:0] e_rd0, e_rd1;
    logic [1:0]  e_conf;
    logic [31:0] e_busy;
  } vec_t;

  typedef struct {
    logic [31:0] rd0, rd1;
    logic [1:0]  conf;
  } exp_t;

  vec_t vt[11];
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [1:0] rn, input logic [4:0] a0, input logic [4:0] a1,
                              input logic rs, input logic [4:0] rsa, input logic fl,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [1:0] cf, input logic [31:0] bz);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd; v.ren = rn; v.ra0 = a0; v.ra1 = a1;
    v.rsv_en = rs; v.rsv_addr = rsa; v.flush = fl;
    v.e_rd0 = d0; v.e_rd1 = d1; v.e_conf = cf; v.e_busy = bz;
    return v;
  endfunction

  task automatic idle();
    rst = 0; flush = 0; we = 0; rsv_en = 0; done = 0; ren = 0;
    raddr = 0; waddr = 0; wdata = 0; rsv_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one table row, queue its expectations, compare settled outputs,
  // then clock it and compare the registered scoreboard.
  task automatic apply(input int n, input vec_t v);
    exp_t e;
    we = v.we; waddr = v.waddr; wdata = v.wdata; ren = v.ren;
    raddr = {v.ra1, v.ra0}; rsv_en = v.rsv_en; rsv_addr = v.rsv_addr; flush = v.flush;
    e.rd0 = v.e_rd0; e.rd1 = v.e_rd1; e.conf = v.e_conf;
    sbq.push_back(e);
    #2;
    if (sbq.size() == 0) begin
      chk($sformatf("v%0d_queue_empty", n), 1, 0);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("v%0d_rdata0", n), rdata[31:0], e.rd0);
      chk($sformatf("v%0d_rdata1", n), rdata[63:32], e.rd1);
      chk($sformatf("v%0d_conflict", n), conflict, e.conf);
    end
    tick();
    idle();
    #1;
    chk($sformatf("v%0d_busy_after", n), busy_mask, v.e_busy);
  endtask

  initial begin
    idle();
    init_val = 32'h7; dbg_addr = 0;
    rst = 1;
    tick();
    rst = 0;
    #1;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = i[4:0];
      #1;
      chk($sformatf("reset_reg%0d", i), dbg_data, (i == 10) ? 32'h7 : 32'h0);
    end
    chk("reset_busy", busy_mask, 0);
    chk("reset_halted", halted, 0);
    ren = 2'b11; raddr = {5'd0, 5'd10};
    #1;
    chk("reset_rdata_arg", rdata, {32'h0, 32'h7});
    chk("reset_conflict", conflict, 0);
    idle();
    tick();

    //            we waddr wdata          ren    ra0  ra1  rsv rsva fl  rd0            rd1            conf   busy
    vt[0]  = mk(1, 5, 32'hDEADBEEF, 2'b11, 5,  10, 0, 0,  0, 32'hDEADBEEF, 32'h7,        2'b00, 32'h0);
    vt[1]  = mk(0, 0, 32'h0,        2'b11, 5,  5,  0, 0,  0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0);
    vt[2]  = mk(0, 0, 32'h0,        2'b01, 3,  0,  1, 3,  0, 32'h0,        32'h0,        2'b00, 32'h8);
    vt[3]  = mk(0, 0, 32'h0,        2'b01, 3,  0,  0, 0,  0, 32'h0,        32'h0,        2'b01, 32'h8);
    vt[4]  = mk(1, 3, 32'h42,       2'b11, 3,  3,  0, 0,  0, 32'h42,       32'h42,       2'b00, 32'h0);
    vt[5]  = mk(1, 7, 32'h77,       2'b01, 7,  0,  1, 7,  0, 32'h77,       32'h0,        2'b00, 32'h80);
    vt[6]  = mk(0, 0, 32'h0,        2'b01, 7,  0,  1, 9,  1, 32'h77,       32'h0,        2'b01, 32'h0);
    vt[7]  = mk(1, 0, 32'h1234,     2'b11, 0,  0,  1, 0,  0, 32'h0,        32'h0,        2'b00, 32'h0);
    vt[8]  = mk(0, 0, 32'h0,        2'b00, 0,  0,  1, 12, 0, 32'h0,        32'h0,        2'b00, 32'h1000);
    vt[9]  = mk(0, 0, 32'h0,        2'b10, 12, 12, 0, 0,  0, 32'h0,        32'h0,        2'b10, 32'h1000);
    vt[10] = mk(0, 0, 32'h0,        2'b00, 3,  5,  0, 0,  1, 32'h42,       32'hDEADBEEF, 2'b00, 32'h0);
    for (int i = 0; i < 11; i++) apply(i, vt[i]);

    dbg_addr = 0; #1;
    chk("reg0_dbg_after_write", dbg_data, 0);

    // Halt: reserve r8 first, then done with a write to r4 in the same cycle
    rsv_en = 1; rsv_addr = 8;
    tick(); idle();
    done = 1; we = 1; waddr = 4; wdata = 32'h99; ren = 2'b01; raddr = {5'd0, 5'd4};
    #2;
    chk("done_cycle_no_bypass", rdata[31:0], 0);
    tick(); idle();
    dbg_addr = 4; #1;
    chk("halt_reg4_unchanged", dbg_data, 0);
    chk("halt_set", halted, 1);
    // While halted: write, reserve and flush all ignored, reads still work
    we = 1; waddr = 4; wdata = 32'h55; rsv_en = 1; rsv_addr = 6; flush = 1;
    ren = 2'b11; raddr = {5'd8, 5'd5};
    #2;
    chk("halted_read", rdata, {32'h0, 32'hDEADBEEF});
    chk("halted_conflict", conflict, 2'b10);
    tick(); idle(); #1;
    chk("halted_reg4", dbg_data, 0);
    chk("halted_busy", busy_mask, 32'h100);
    chk("halt_sticky", halted, 1);

    // Reset overrides a concurrent write/reserve and reloads ARG_REG
    rst = 1; init_val = 32'hABC; we = 1; waddr = 5; wdata = 32'h1; rsv_en = 1; rsv_addr = 2;
    tick(); idle(); #1;
    chk("rerst_halted", halted, 0);
    chk("rerst_busy", busy_mask, 0);
    dbg_addr = 10; #1;
    chk("rerst_arg", dbg_data, 32'hABC);
    dbg_addr = 5; #1;
    chk("rerst_reg5", dbg_data, 0);
    // Writes work again after reset
    we = 1; waddr = 6; wdata = 32'h600D;
    tick(); idle();
    dbg_addr = 6; #1;
    chk("post_rerst_write", dbg_data, 32'h600D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
